// File: rtl/delay_timer.sv
// -----------------------------------------------------------------------------
// delay_timer
//
// Purpose:
//   Programmable delay generator. A rising edge on start_strobe_in, while
//   enable_in is high, starts a delay of value_in units. Each unit lasts
//   PRESCALE_DIV clock cycles. While the delay runs, busy_out is high and
//   remaining_out shows the number of units still to elapse. When the delay
//   completes normally, done_out pulses for one cycle. Dropping enable_in
//   aborts the delay silently, with no done_out pulse.
//
// Parameters:
//   DELAY_BITS    width of value_in / remaining_out and of the unit counter
//   PRESCALE_DIV  clock cycles per delay unit (1..65535)
//
// Ports:
//   clock_in         in   1           sole clock, rising edge
//   reset_n_in       in   1           asynchronous active-low reset
//   enable_in        in   1           delay enable; low aborts any delay
//   start_strobe_in  in   1           start request (rising edge acted on)
//   value_in         in   DELAY_BITS  delay length in units, sampled on start
//   busy_out         out  1           high while a delay is counting
//   done_out         out  1           one-cycle pulse on normal completion
//   remaining_out    out  DELAY_BITS  units still to elapse, 0 when idle
//
// Build option:
//   DELAY_TIMER_RETRIGGER_EN
//     When defined, a start edge during COUNT reloads the delay. A start edge
//     with value_in = 0 ends the delay as a normal completion. When the macro
//     is undefined, start edges during COUNT are ignored and no retrigger
//     logic exists.
// -----------------------------------------------------------------------------
module delay_timer #(
    parameter int DELAY_BITS   = 16,
    parameter int PRESCALE_DIV = 10
) (
    input  logic                  clock_in,
    input  logic                  reset_n_in,
    input  logic                  enable_in,
    input  logic                  start_strobe_in,
    input  logic [DELAY_BITS-1:0] value_in,
    output logic                  busy_out,
    output logic                  done_out,
    output logic [DELAY_BITS-1:0] remaining_out
);

    // A divide-by-1 prescaler still needs one bit so that the vector has a
    // legal width. In that case the bit simply stays at zero.
    localparam int PRESC_BITS = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam logic [PRESC_BITS-1:0] PRESC_RELOAD = PRESC_BITS'(PRESCALE_DIV - 1);
    localparam logic [PRESC_BITS-1:0] PRESC_ONE    = PRESC_BITS'(1);
    localparam logic [DELAY_BITS-1:0] UNIT_ONE     = DELAY_BITS'(1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic                  start_prev_q;
    logic [DELAY_BITS-1:0] unit_q, unit_d;
    logic [PRESC_BITS-1:0] presc_q, presc_d;
    logic                  done_q, done_d;

    logic                  start_edge;
    logic                  value_zero;
    logic                  presc_zero;

    // start_prev_q resets to 0. As a result, a strobe that is already high
    // when reset is released counts as an edge on the first clock.
    assign start_edge = start_strobe_in & ~start_prev_q;
    assign value_zero = (value_in == '0);
    assign presc_zero = (presc_q == '0);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q      <= ST_IDLE;
            start_prev_q <= 1'b0;
            unit_q       <= '0;
            presc_q      <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_strobe_in;
            unit_q       <= unit_d;
            presc_q      <= presc_d;
            done_q       <= done_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unit_d  = unit_q;
        presc_d = presc_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable_in && start_edge) begin
                    if (value_zero) begin
                        // A zero-length delay completes at once: no busy
                        // window, just the done pulse.
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_COUNT;
                        unit_d  = value_in;
                        presc_d = PRESC_RELOAD;
                    end
                end
            end

            ST_COUNT: begin
                if (!enable_in) begin
                    // An abort beats both completion and retrigger.
                    state_d = ST_IDLE;
                    unit_d  = '0;
                    presc_d = '0;
                end
`ifdef DELAY_TIMER_RETRIGGER_EN
                else if (start_edge) begin
                    if (value_zero) begin
                        state_d = ST_IDLE;
                        unit_d  = '0;
                        presc_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        unit_d  = value_in;
                        presc_d = PRESC_RELOAD;
                    end
                end
`endif
                else if (presc_zero) begin
                    // The final tick of the last unit ends the delay. Using
                    // '<=' also stops the counter from ever wrapping below 0.
                    if (unit_q <= UNIT_ONE) begin
                        state_d = ST_IDLE;
                        unit_d  = '0;
                        presc_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        unit_d  = unit_q - UNIT_ONE;
                        presc_d = PRESC_RELOAD;
                    end
                end else begin
                    presc_d = presc_q - PRESC_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                unit_d  = '0;
                presc_d = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs (all taken straight from registers)
    // -------------------------------------------------------------------------
    assign busy_out      = (state_q == ST_COUNT);
    assign done_out      = done_q;
    assign remaining_out = (state_q == ST_COUNT) ? unit_q : '0;

endmodule

// File: tb/tb_delay_timer.sv
// -----------------------------------------------------------------------------
// tb_delay_timer
//
// Directed bench for delay_timer with PRESCALE_DIV = 4.
// - A vector table drives single-start scenarios. Each scenario is checked
//   cycle by cycle against its expected busy window, done-pulse index and
//   remaining count.
// - Hand-written sequences cover:
//     * a start strobe held high across completion,
//     * reset asserted in the middle of a count,
//     * a strobe already high when reset is released,
//     * a second start edge during COUNT.
// - The expected result of the second-start sequence depends on
//   DELAY_TIMER_RETRIGGER_EN.
// -----------------------------------------------------------------------------
module tb_delay_timer;

    localparam int DB  = 16;
    localparam int PD  = 4;
    localparam int WIN = 20;
    localparam int NV  = 7;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          en    = 1'b0;
    logic          start = 1'b0;
    logic [DB-1:0] value = '0;
    logic          busy;
    logic          done;
    logic [DB-1:0] rem;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic          en;
        logic [DB-1:0] value;
        int            drop_after;  // drop enable after this many busy samples, 0 = never
        int            busy_len;    // expected busy samples, starting at sample 0
        int            done_idx;    // sample index of the done pulse, -1 = none
    } vec_t;

    vec_t vecs [NV];

    int exp_busy;
    int exp_rem;
    int busy_cnt;
    int done_cnt;
    int rises;
    int done_at;
    logic prev_busy;

    delay_timer #(
        .DELAY_BITS   (DB),
        .PRESCALE_DIV (PD)
    ) dut (
        .clock_in        (clk),
        .reset_n_in      (rst_n),
        .enable_in       (en),
        .start_strobe_in (start),
        .value_in        (value),
        .busy_out        (busy),
        .done_out        (done),
        .remaining_out   (rem)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    // Wait for the next rising edge, then step 1 time unit past it so that
    // the outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        start = 1'b0;
        en    = 1'b1;
        value = '0;
        repeat (3) tick();
    endtask

    // Time-limit guard: if a wait never ends, report it and stop the run.
    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            en    value  drop busy done
        vecs[0] = '{1'b1, 16'd3, 0,   12,  12};   // basic 3-unit delay
        vecs[1] = '{1'b1, 16'd0, 0,   0,   0};    // zero length: done only
        vecs[2] = '{1'b1, 16'd5, 7,   7,   -1};   // abort after 7 busy cycles
        vecs[3] = '{1'b0, 16'd3, 0,   0,   -1};   // start ignored while disabled
        vecs[4] = '{1'b1, 16'd1, 4,   4,   -1};   // abort wins over completion
        vecs[5] = '{1'b1, 16'd2, 0,   8,   8};
        vecs[6] = '{1'b1, 16'd1, 0,   4,   4};

        // ---------------- reset state ----------------
        repeat (2) tick();
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset rem",  int'(rem),  0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- vector table ----------------
        for (int i = 0; i < NV; i++) begin
            settle();
            @(negedge clk);
            en    = vecs[i].en;
            start = 1'b1;
            value = vecs[i].value;
            tick();
            for (int c = 0; c < WIN; c++) begin
                exp_busy = (c < vecs[i].busy_len) ? 1 : 0;
                exp_rem  = (exp_busy == 1) ? (int'(vecs[i].value) - c / PD) : 0;
                check($sformatf("v%0d busy c%0d", i, c), int'(busy), exp_busy);
                check($sformatf("v%0d done c%0d", i, c), int'(done),
                      (c == vecs[i].done_idx) ? 1 : 0);
                check($sformatf("v%0d rem c%0d", i, c), int'(rem), exp_rem);
                @(negedge clk);
                start = 1'b0;
                if (vecs[i].drop_after > 0 && c + 1 == vecs[i].drop_after)
                    en = 1'b0;
                tick();
            end
        end

        // ---------------- strobe held high across completion ----------------
        settle();
        @(negedge clk);
        start     = 1'b1;
        value     = 16'd2;
        busy_cnt  = 0;
        done_cnt  = 0;
        rises     = 0;
        prev_busy = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (busy) busy_cnt++;
            if (busy && !prev_busy) rises++;
            prev_busy = busy;
            if (done) done_cnt++;
            @(negedge clk);
            if (c == 19) start = 1'b0;
        end
        check("held busy cycles", busy_cnt, 8);
        check("held busy windows", rises, 1);
        check("held done pulses", done_cnt, 1);

        // ---------------- reset mid-count ----------------
        settle();
        @(negedge clk);
        start = 1'b1;
        value = 16'd3;
        tick();
        @(negedge clk);
        start = 1'b0;
        repeat (4) tick();
        check("pre-reset busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async rst busy", int'(busy), 0);
        check("async rst done", int'(done), 0);
        check("async rst rem",  int'(rem),  0);
        @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (busy) busy_cnt++;
            if (done) done_cnt++;
        end
        check("post-reset busy", busy_cnt, 0);
        check("post-reset done", done_cnt, 0);

        // ---------------- strobe already high at reset release ----------------
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        en    = 1'b1;
        value = 16'd2;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("release start busy", int'(busy), 1);
        check("release start rem",  int'(rem),  2);
        @(negedge clk);
        start = 1'b0;
        repeat (10) tick();
        check("release start idle", int'(busy), 0);

        // ---------------- second start edge during COUNT ----------------
        settle();
        @(negedge clk);
        start     = 1'b1;
        value     = 16'd4;
        busy_cnt  = 0;
        done_cnt  = 0;
        rises     = 0;
        done_at   = -1;
        prev_busy = 1'b0;
        tick();
        for (int c = 0; c < 30; c++) begin
            if (busy) busy_cnt++;
            if (busy && !prev_busy) rises++;
            prev_busy = busy;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            @(negedge clk);
            start = (c == 4);
            if (c == 4) value = 16'd2;
            tick();
        end
`ifdef DELAY_TIMER_RETRIGGER_EN
        check("retrig busy cycles", busy_cnt, 13);
        check("retrig done index", done_at, 13);
`else
        check("no-retrig busy cycles", busy_cnt, 16);
        check("no-retrig done index", done_at, 16);
`endif
        check("second edge windows", rises, 1);
        check("second edge dones", done_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
